// File: rtl/sdm_multi.sv
// sdm_multi: N-channel order-1/order-2 sigma-delta modulator with saturating guard-bit integrators
// and sticky per-channel overflow flags. Define SDM_DITHER_EN to add shared-LFSR LSB dither.
module sdm_multi #(
  parameter int CHANNELS  = 4,
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int ORDER     = 1,
  parameter int GUARD     = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          en,
  input  logic [CHANNELS*BIT_WIDTH-1:0] x,
  input  logic                          clear_ovf,
  output logic [CHANNELS-1:0]           y,
  output logic                          y_valid,
  output logic [CHANNELS-1:0]           ovf
);

  localparam int ACC_WIDTH = BIT_WIDTH + GUARD;
  // Two headroom bits: integrator + input + feedback can never wrap before the clamp.
  localparam int SUM_WIDTH = ACC_WIDTH + 2;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [SUM_WIDTH-1:0] sum_t;

  localparam sum_t ONE     = sum_t'(2 ** (BIT_WIDTH - INT_WIDTH - 1));
  localparam sum_t NEG_ONE = -ONE;
  localparam sum_t ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam sum_t ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sdm_multi: ORDER must be 1 or 2");
  end

  function automatic sum_t ext(input acc_t v);
    return {{2{v[ACC_WIDTH-1]}}, v};
  endfunction

  // Returns {clamped, value}.
  function automatic logic [ACC_WIDTH:0] sat_acc(input sum_t v);
    logic [ACC_WIDTH:0] r;
    if (v > ACC_MAX)      r = {1'b1, ACC_MAX[ACC_WIDTH-1:0]};
    else if (v < ACC_MIN) r = {1'b1, ACC_MIN[ACC_WIDTH-1:0]};
    else                  r = {1'b0, v[ACC_WIDTH-1:0]};
    return r;
  endfunction

`ifdef SDM_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting Galois
  logic [15:0] lfsr;
`endif

  acc_t                i1_q [CHANNELS];
  acc_t                i2_q [CHANNELS];
  acc_t                i1_d [CHANNELS];
  acc_t                i2_d [CHANNELS];
  logic [CHANNELS-1:0] y_d;
  logic [CHANNELS-1:0] sat_hit;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sum_t x_ext;
    sum_t fb;
    sum_t dith;
    sum_t sum1;
    logic sat1;
    logic sat2;

    assign x_ext = {{(SUM_WIDTH-BIT_WIDTH){x[c*BIT_WIDTH+BIT_WIDTH-1]}}, x[c*BIT_WIDTH +: BIT_WIDTH]};
    assign fb    = y[c] ? ONE : NEG_ONE;
`ifdef SDM_DITHER_EN
    assign dith  = sum_t'(lfsr[c % 16]);
`else
    assign dith  = '0;
`endif
    assign sum1               = ext(i1_q[c]) + x_ext + dith - fb;
    assign {sat1, i1_d[c]}    = sat_acc(sum1);

    if (ORDER == 2) begin : g_o2
      sum_t sum2;
      // CIFB: the second integrator consumes the freshly updated first integrator.
      assign sum2            = ext(i2_q[c]) + ext(i1_d[c]) - fb;
      assign {sat2, i2_d[c]} = sat_acc(sum2);
      assign y_d[c]          = ~i2_d[c][ACC_WIDTH-1];
    end else begin : g_o1
      assign sat2    = 1'b0;
      assign i2_d[c] = i2_q[c];
      assign y_d[c]  = ~i1_d[c][ACC_WIDTH-1];
    end

    assign sat_hit[c] = sat1 | sat2;
  end

  // NOTE: all state uses non-blocking assignments so every channel's feedback sees the pre-edge y.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      y       <= '0;
      y_valid <= 1'b0;
      ovf     <= '0;
      // NOTE: the integrator arrays are plain flop banks, not RAM, so they reset like any register.
      for (int c = 0; c < CHANNELS; c++) begin
        i1_q[c] <= '0;
        i2_q[c] <= '0;
      end
`ifdef SDM_DITHER_EN
      lfsr <= LFSR_SEED;
`endif
    end else begin
      y_valid <= en;
      // A clamp in the same cycle as clear_ovf keeps its flag set.
      ovf <= (clear_ovf ? {CHANNELS{1'b0}} : ovf) | (en ? sat_hit : {CHANNELS{1'b0}});
      if (en) begin
        y <= y_d;
        for (int c = 0; c < CHANNELS; c++) begin
          i1_q[c] <= i1_d[c];
          i2_q[c] <= i2_d[c];
        end
`ifdef SDM_DITHER_EN
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sdm_multi.sv
// Self-checking bench for sdm_multi: three instances (order 1, narrow-guard order 1, order 2)
// compared every cycle against an arithmetic reference model, plus directed density/overflow checks.
`timescale 1ns/1ps
module tb_sdm_multi;

  localparam int NK = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        clear_ovf;
  logic [63:0] x_bus [NK];
  logic [3:0]  y_o   [NK];
  logic [3:0]  ovf_o [NK];
  logic        v_o   [NK];

  always #5 clk = ~clk;

  sdm_multi u_a (
    .CLK(clk), .nRST(nrst), .en(en), .x(x_bus[0]), .clear_ovf(clear_ovf),
    .y(y_o[0]), .y_valid(v_o[0]), .ovf(ovf_o[0])
  );

  sdm_multi #(.INT_WIDTH(3), .GUARD(1)) u_b (
    .CLK(clk), .nRST(nrst), .en(en), .x(x_bus[1]), .clear_ovf(clear_ovf),
    .y(y_o[1]), .y_valid(v_o[1]), .ovf(ovf_o[1])
  );

  sdm_multi #(.ORDER(2)) u_c (
    .CLK(clk), .nRST(nrst), .en(en), .x(x_bus[2]), .clear_ovf(clear_ovf),
    .y(y_o[2]), .y_valid(v_o[2]), .ovf(ovf_o[2])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference model: integrators as plain integers, modulator equations applied directly.
  int       m_one  [NK] = '{16384, 4096, 16384};
  int       m_accw [NK] = '{20, 17, 20};
  int       m_ord  [NK] = '{1, 1, 2};
  longint   m_i1   [NK][4];
  longint   m_i2   [NK][4];
  bit [3:0] m_y    [NK];
  bit [3:0] m_ovf  [NK];
  bit       m_valid;
  bit [15:0] m_lfsr;

  function automatic longint sat(input longint v, input int w, output bit hit);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    hit = 1'b0;
    if (v > hi) begin hit = 1'b1; return hi; end
    if (v < lo) begin hit = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_clock();
    if (!nrst) begin
      m_valid = 1'b0;
      m_lfsr  = 16'hACE1;
      for (int k = 0; k < NK; k++) begin
        m_y[k] = '0;
        m_ovf[k] = '0;
        for (int c = 0; c < 4; c++) begin
          m_i1[k][c] = 0;
          m_i2[k][c] = 0;
        end
      end
    end else begin
      m_valid = en;
      for (int k = 0; k < NK; k++) begin
        for (int c = 0; c < 4; c++) begin
          longint xs, fb, d;
          bit h1, h2;
          if (clear_ovf) m_ovf[k][c] = 1'b0;
          if (en) begin
            xs = longint'($signed(x_bus[k][c*16 +: 16]));
            fb = m_y[k][c] ? m_one[k] : -m_one[k];
            d  = 0;
`ifdef SDM_DITHER_EN
            d  = m_lfsr[c % 16];
`endif
            m_i1[k][c] = sat(m_i1[k][c] + xs + d - fb, m_accw[k], h1);
            h2 = 1'b0;
            if (m_ord[k] == 2) m_i2[k][c] = sat(m_i2[k][c] + m_i1[k][c] - fb, m_accw[k], h2);
            m_y[k][c] = ((m_ord[k] == 2) ? m_i2[k][c] : m_i1[k][c]) >= 0;
            if (h1 || h2) m_ovf[k][c] = 1'b1;
          end
        end
      end
      if (en) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NK; k++) begin
      check($sformatf("inst%0d_y", k), y_o[k], m_y[k]);
      check($sformatf("inst%0d_y_valid", k), v_o[k], m_valid);
      check($sformatf("inst%0d_ovf", k), ovf_o[k], m_ovf[k]);
    end
  endtask

  // One clock: inputs already driven, model advances with the edge, outputs sampled 1 ns later.
  task automatic step(input bit e, input bit clr = 1'b0);
    en = e;
    clear_ovf = clr;
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step(1'b1);
    nrst = 1'b1;
  endtask

  task automatic set_x(input int k, input logic [15:0] v);
    for (int c = 0; c < 4; c++) x_bus[k][c*16 +: 16] = v;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       ones0, ones1;
    logic [7:0] seq;
    logic [3:0] vseq;

    nrst = 1'b1;
    en = 1'b0;
    clear_ovf = 1'b0;
    for (int k = 0; k < NK; k++) set_x(k, 16'h0000);

    // Reset state and zero-input idle tone.
    do_reset();
    check("reset_y", y_o[0], 4'h0);
    check("reset_valid", v_o[0], 1'b0);
    ones0 = 0;
    seq = '0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1);
      if (i < 8) seq[i] = y_o[0][0];
      ones0 += y_o[0][0];
    end
    check("zero_seq", seq, 8'hAB);
    check("zero_ones", ones0, 33);
    check("zero_ovf", ovf_o[0], 4'h0);

`ifdef SDM_DITHER_EN
    do_reset();
    ones0 = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1);
      ones0 += y_o[0][0];
    end
    check_range("dither_zero_ones", ones0, 124, 132);
`endif

    // Half-scale densities; channels carry different inputs.
    do_reset();
    x_bus[0] = {16'h0000, 16'h1000, 16'hE000, 16'h2000};
    ones0 = 0;
    ones1 = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1);
      ones0 += y_o[0][0];
      ones1 += y_o[0][1];
    end
    check_range("half_pos_ones", ones0, 47, 49);
    check_range("half_neg_ones", ones1, 15, 17);

    // Full-scale +ONE: every output bit is 1, no overflow.
    do_reset();
    set_x(0, 16'h4000);
    for (int i = 0; i < 16; i++) begin
      step(1'b1);
      check("full_scale_y", y_o[0], 4'hF);
    end
    check("full_scale_ovf", ovf_o[0], 4'h0);

    // Overload on the narrow-guard instance: sticky flag, clamp, clear behaviour.
    do_reset();
    set_x(1, 16'h7FFF);
    for (int i = 0; i < 8; i++) step(1'b1);
    check("sat_ovf_set", ovf_o[1], 4'hF);
    check("sat_i1_clamp", u_b.i1_q[0], 64'h0FFFF);
    step(1'b1, 1'b1);
    check("sat_clear_loses", ovf_o[1], 4'hF);
    set_x(1, 16'h0000);
    step(1'b1);
    check("sat_ovf_sticky", ovf_o[1], 4'hF);
    step(1'b0, 1'b1);
    check("sat_ovf_cleared", ovf_o[1], 4'h0);

    // Gapped strobe 1,0,0,1 then a one-cycle reset mid-stream.
    do_reset();
    set_x(0, 16'h0000);
    vseq = '0;
    step(1'b1); vseq[0] = v_o[0];
    step(1'b0); vseq[1] = v_o[0];
    check("gap_hold1", y_o[0], 4'hF);
    step(1'b0); vseq[2] = v_o[0];
    check("gap_hold2", y_o[0], 4'hF);
    step(1'b1); vseq[3] = v_o[0];
    check("gap_valid_seq", vseq, 4'b1001);
    for (int i = 0; i < 5; i++) step(1'b1);
    do_reset();
    check("midreset_y", y_o[0], 4'h0);
    check("midreset_ovf", ovf_o[0], 4'h0);
    check("midreset_valid", v_o[0], 1'b0);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      seq[i] = y_o[0][0];
    end
    check("restart_seq", seq, 8'hAB);

    // Second-order loop at +ONE/4.
    do_reset();
    set_x(2, 16'h1000);
    ones0 = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1);
      ones0 += y_o[2][0];
    end
    check_range("order2_ones", ones0, 158, 162);
    check("order2_ovf", ovf_o[2], 4'h0);

    // Random traffic against the model: gapped strobes, clears, rare resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) begin
        int r;
        r = int'($urandom_range(0, 32768)) - 16384;
        x_bus[0][c*16 +: 16] = 16'(r);
        x_bus[1][c*16 +: 16] = 16'($urandom);
        x_bus[2][c*16 +: 16] = 16'($urandom);
      end
      nrst = ($urandom_range(0, 127) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    nrst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
